// File: rtl/spi_cmd_parser.sv
// SPI RX FIFO read-side command parser for the SPI-to-I2C bridge.
// Turns {addr,rw}, len[, payload] byte frames into an I2C command handshake plus a write-data stream.
module spi_cmd_parser #(
  parameter  int unsigned MAX_LEN = 16,
  parameter  int unsigned TIMEOUT = 1024,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             rd_empty,
  input  logic [7:0]       rd_data,
  output logic             rd_en,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [6:0]       cmd_addr,
  output logic             cmd_rw,
  output logic [LEN_W-1:0] cmd_len,
  output logic             wdata_valid,
  input  logic             wdata_ready,
  output logic [7:0]       wdata,
  output logic             wdata_last,
  output logic             busy,
  output logic             err_len,
  output logic             err_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_HDR, S_LEN, S_CMD, S_DATA} state_t;

  state_t           state;
  logic             pend;
  logic [LEN_W-1:0] rem;
  logic [TW-1:0]    tcnt;
  logic             need_byte;
  logic             stall;
  logic             expire;
  logic             len_bad;

  always_comb begin
    need_byte = (state == S_HDR) || (state == S_LEN) || (state == S_DATA);
    // Reset gates the pop so an idle-state parser cannot drain the FIFO while held in reset.
    rd_en     = rd_rst_n && need_byte && !rd_empty && !pend && !wdata_valid;
    stall     = ((state == S_LEN) || (state == S_DATA)) && rd_empty && !pend && !wdata_valid;
    expire    = stall && (tcnt == TW'(TIMEOUT - 1));
    len_bad   = (rd_data == 8'd0) || (32'(rd_data) > MAX_LEN);
    busy      = (state != S_HDR) || pend;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state       <= S_HDR;
      pend        <= 1'b0;
      rem         <= '0;
      tcnt        <= '0;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_rw      <= 1'b0;
      cmd_len     <= '0;
      wdata_valid <= 1'b0;
      wdata       <= '0;
      wdata_last  <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      pend        <= rd_en;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      tcnt        <= stall ? tcnt + 1'b1 : '0;
      if (expire) begin
        state       <= S_HDR;
        tcnt        <= '0;
        err_timeout <= 1'b1;
        wdata_valid <= 1'b0;
        wdata_last  <= 1'b0;
      end else begin
        unique case (state)
          S_HDR: begin
            if (pend) begin
              cmd_addr <= rd_data[7:1];
              cmd_rw   <= rd_data[0];
              state    <= S_LEN;
            end
          end
          S_LEN: begin
            if (pend) begin
              if (len_bad) begin
                err_len <= 1'b1;
                state   <= S_HDR;
              end else begin
                cmd_len   <= LEN_W'(rd_data);
                rem       <= LEN_W'(rd_data);
                cmd_valid <= 1'b1;
                state     <= S_CMD;
              end
            end
          end
          S_CMD: begin
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              state     <= cmd_rw ? S_HDR : S_DATA;
            end
          end
          S_DATA: begin
            if (pend) begin
              wdata       <= rd_data;
              wdata_valid <= 1'b1;
              wdata_last  <= (rem == LEN_W'(1));
            end else if (wdata_valid && wdata_ready) begin
              wdata_valid <= 1'b0;
              wdata_last  <= 1'b0;
              if (rem != '0) rem <= rem - 1'b1;
              if (rem == LEN_W'(1)) state <= S_HDR;
            end
          end
        endcase
      end
    end
  end

endmodule
